// File: rtl/pico_puf_pkg.sv
`default_nettype none
// ============================================================================
// Module : pico_puf_pkg
// Brief  : Shared types and elaboration helpers for the PUF array controller.
//          - state_t         : sequencer states IDLE/ARM/EVAL/VOTE/DONE
//          - ones_width()    : width of the per-bit ones counter
//          - eval_count_ok() : NUM_EVAL must be odd and >= 1
//          - settle_ok()     : SETTLE_CYC must be >= 1
// Rev    : 1.0  initial release
// ============================================================================
package pico_puf_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        EVAL = 3'd2,
        VOTE = 3'd3,
        DONE = 3'd4
    } state_t;

    // Counter must hold the value NUM_EVAL itself (all samples were 1).
    function automatic int ones_width(input int num_eval);
        return (num_eval < 1) ? 1 : $clog2(num_eval + 1);
    endfunction

    // An even evaluation count could tie, which the majority rule cannot break.
    function automatic bit eval_count_ok(input int num_eval);
        return (num_eval >= 1) && ((num_eval % 2) == 1);
    endfunction

    function automatic bit settle_ok(input int settle_cyc);
        return settle_cyc >= 1;
    endfunction

endpackage : pico_puf_pkg
`default_nettype wire

// File: rtl/pico_puf_vote.sv
`default_nettype none
// ============================================================================
// Module : pico_puf_vote
// Brief  : Majority voter for one response bit. Accumulates the sampled cell
//          outputs over NUM_EVAL evaluations and presents the decision.
//          Optional macro: PICO_PUF_UNSTABLE_FLAG_EN adds the unanimity flag.
// Ports  : clk           system clock
//          clear         asynchronous active-low reset
//          start         synchronous clear of both counters (new request)
//          sample_en     one cell sample is presented on sample_bit
//          sample_bit    sampled cell output
//          vote_en       decision consumed; counters return to zero
//          last_eval     the pending sample is the final one for this bit
//          vote_bit      majority decision (ones > NUM_EVAL/2)
//          vote_unstable samples disagreed (only with the macro defined)
// Rev    : 1.0  initial release
// ============================================================================
module pico_puf_vote
    import pico_puf_pkg::*;
#(
    parameter int NUM_EVAL = 7,
    parameter int CNT_W    = ones_width(NUM_EVAL)
) (
    input  logic clk,
    input  logic clear,
    input  logic start,
    input  logic sample_en,
    input  logic sample_bit,
    input  logic vote_en,
    output logic last_eval,
`ifdef PICO_PUF_UNSTABLE_FLAG_EN
    output logic vote_unstable,
`endif
    output logic vote_bit
);

    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(NUM_EVAL - 1);
    localparam logic [CNT_W-1:0] c_half  = CNT_W'(NUM_EVAL / 2);

    logic [CNT_W-1:0] r_ones;
    logic [CNT_W-1:0] r_eval_cnt;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_ones     <= '0;
            r_eval_cnt <= '0;
        end else if (start || vote_en) begin
            r_ones     <= '0;
            r_eval_cnt <= '0;
        end else if (sample_en) begin
            r_ones     <= r_ones + (sample_bit ? c_one : '0);
            r_eval_cnt <= r_eval_cnt + c_one;
        end
    end

    assign last_eval = (r_eval_cnt == c_last);
    assign vote_bit  = (r_ones > c_half);

`ifdef PICO_PUF_UNSTABLE_FLAG_EN
    localparam logic [CNT_W-1:0] c_all = CNT_W'(NUM_EVAL);
    assign vote_unstable = (r_ones != '0) && (r_ones != c_all);
`endif

endmodule : pico_puf_vote
`default_nettype wire

// File: rtl/pico_puf_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pico_puf_array_ctrl
// Brief  : Sequences an external array of NUM_CELLS PUF cells. Each response
//          bit is evaluated NUM_EVAL times (ARM: all cells held in clear,
//          EVAL: selected cell released for SETTLE_CYC cycles and sampled on
//          the last one), majority-voted, and packed into resp_data.
//          Optional macro: PICO_PUF_UNSTABLE_FLAG_EN adds resp_unstable.
// Ports  : clk            system clock, rising edge
//          clear          asynchronous active-low reset
//          req_valid/req_ready/req_chal   challenge request (start cell)
//          cell_clear     active-low clear to each cell, one bit high in EVAL
//          cell_resp      raw cell outputs; only the selected bit is used
//          resp_valid/resp_ready/resp_data  voted response, bit 0 first
//          resp_unstable  per-bit non-unanimous flag (macro only)
// Rev    : 1.0  initial release
// ============================================================================
module pico_puf_array_ctrl
    import pico_puf_pkg::*;
#(
    parameter int NUM_CELLS  = 16,
    parameter int RESP_W     = 8,
    parameter int NUM_EVAL   = 7,
    parameter int SETTLE_CYC = 4,
    parameter int CHAL_W     = $clog2(NUM_CELLS)
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CHAL_W-1:0]    req_chal,
    output logic [NUM_CELLS-1:0] cell_clear,
    input  logic [NUM_CELLS-1:0] cell_resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
`ifdef PICO_PUF_UNSTABLE_FLAG_EN
    output logic [RESP_W-1:0]    resp_unstable,
`endif
    output logic [RESP_W-1:0]    resp_data
);

    // ------------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------------
    if (!eval_count_ok(NUM_EVAL)) begin : g_chk_eval
        $fatal(1, "pico_puf_array_ctrl: NUM_EVAL must be odd and >= 1");
    end
    if (!settle_ok(SETTLE_CYC)) begin : g_chk_settle
        $fatal(1, "pico_puf_array_ctrl: SETTLE_CYC must be >= 1");
    end

    localparam int c_set_w = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_bit_w = $clog2(RESP_W + 1);

    localparam logic [c_set_w-1:0]   c_set_one  = c_set_w'(1);
    localparam logic [c_set_w-1:0]   c_set_last = c_set_w'(SETTLE_CYC - 1);
    localparam logic [c_bit_w-1:0]   c_bit_one  = c_bit_w'(1);
    localparam logic [c_bit_w-1:0]   c_bit_last = c_bit_w'(RESP_W - 1);
    localparam logic [CHAL_W-1:0]    c_idx_one  = CHAL_W'(1);
    localparam logic [NUM_CELLS-1:0] c_cell_one = NUM_CELLS'(1);
    localparam logic [RESP_W-1:0]    c_resp_one = RESP_W'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CHAL_W-1:0]      r_idx;
    logic [c_set_w-1:0]     r_settle_cnt;
    logic [c_bit_w-1:0]     r_bit_cnt;
    logic [NUM_CELLS-1:0]   r_cell_clear;
    logic [NUM_CELLS-1:0]   w_cell_clear_nxt;
    logic                   r_req_ready;
    logic                   r_resp_valid;
    logic [RESP_W-1:0]      r_resp_data;
    logic [RESP_W-1:0]      w_bit_mask;

    logic w_accept;
    logic w_sample;
    logic w_vote;
    logic w_settle_last;
    logic w_bit_last;
    logic w_last_eval;
    logic w_vote_bit;

    // r_req_ready gates acceptance so nothing is taken in the first cycle
    // after reset release, before req_ready has been presented.
    assign w_accept      = (r_state == IDLE) && r_req_ready && req_valid;
    assign w_settle_last = (r_settle_cnt == c_set_last);
    assign w_sample      = (r_state == EVAL) && w_settle_last;
    assign w_vote        = (r_state == VOTE);
    assign w_bit_last    = (r_bit_cnt == c_bit_last);
    assign w_bit_mask    = c_resp_one << r_bit_cnt;

    // ------------------------------------------------------------------------
    // Vote accumulator
    // ------------------------------------------------------------------------
`ifdef PICO_PUF_UNSTABLE_FLAG_EN
    logic                   w_vote_unstable;
    logic [RESP_W-1:0]      r_resp_unstable;
`endif

    pico_puf_vote #(
        .NUM_EVAL      (NUM_EVAL)
    ) u_vote (
        .clk           (clk),
        .clear         (clear),
        .start         (w_accept),
        .sample_en     (w_sample),
        .sample_bit    (cell_resp[r_idx]),
        .vote_en       (w_vote),
        .last_eval     (w_last_eval),
`ifdef PICO_PUF_UNSTABLE_FLAG_EN
        .vote_unstable (w_vote_unstable),
`endif
        .vote_bit      (w_vote_bit)
    );

    // ------------------------------------------------------------------------
    // Next-state and next-output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cell_clear_nxt = '0;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = ARM;
            ARM:  w_state_nxt = EVAL;
            EVAL: begin
                if (w_settle_last) begin
                    w_state_nxt = w_last_eval ? VOTE : ARM;
                end
            end
            VOTE: w_state_nxt = w_bit_last ? DONE : ARM;
            DONE: if (resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Outputs are registered, so the release pattern is decoded from
        // the state being entered. r_idx only moves in VOTE, never while
        // heading into EVAL.
        if (w_state_nxt == EVAL) begin
            w_cell_clear_nxt = c_cell_one << r_idx;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_settle_cnt <= '0;
            r_bit_cnt    <= '0;
            r_cell_clear <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cell_clear <= w_cell_clear_nxt;
            r_req_ready  <= (w_state_nxt == IDLE);
            r_resp_valid <= (w_state_nxt == DONE);

            if ((r_state == EVAL) && !w_settle_last) begin
                r_settle_cnt <= r_settle_cnt + c_set_one;
            end else begin
                r_settle_cnt <= '0;
            end

            if (w_accept) begin
                r_idx     <= req_chal;
                r_bit_cnt <= '0;
            end else if (w_vote) begin
                // Power-of-two array: natural overflow is the modulo wrap.
                r_idx       <= r_idx + c_idx_one;
                r_bit_cnt   <= r_bit_cnt + c_bit_one;
                r_resp_data <= (r_resp_data & ~w_bit_mask) |
                               (w_vote_bit ? w_bit_mask : '0);
            end
        end
    end

`ifdef PICO_PUF_UNSTABLE_FLAG_EN
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_resp_unstable <= '0;
        end else if (w_vote) begin
            r_resp_unstable <= (r_resp_unstable & ~w_bit_mask) |
                               (w_vote_unstable ? w_bit_mask : '0);
        end
    end
    assign resp_unstable = r_resp_unstable;
`endif

    assign req_ready  = r_req_ready;
    assign cell_clear = r_cell_clear;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

endmodule : pico_puf_array_ctrl
`default_nettype wire

// File: tb/tb_pico_puf_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pico_puf_array_ctrl
// Brief  : Self-checking bench. Drives a default-parameter controller and a
//          minimal one (NUM_EVAL=1, SETTLE_CYC=1, RESP_W=1) against stub
//          cells whose per-evaluation outputs come from tables; expected
//          responses come from a majority-vote model over those tables.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pico_puf_array_ctrl;

    localparam int NC  = 16;
    localparam int RW  = 8;
    localparam int NE  = 7;
    localparam int ST  = 4;
    localparam int LAT = RW * (NE * (1 + ST) + 1) + 1;
    localparam int NCS = 4;
    localparam int LAT_S = 4;

    logic clk = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    // default-parameter DUT
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_chal = '0;
    logic [NC-1:0] cell_clear;
    logic [NC-1:0] cell_resp;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [RW-1:0] resp_data;
`ifdef PICO_PUF_UNSTABLE_FLAG_EN
    logic [RW-1:0] resp_unstable;
`endif

    // minimal DUT
    logic           req_valid_s = 1'b0;
    logic           req_ready_s;
    logic [1:0]     req_chal_s = '0;
    logic [NCS-1:0] cell_clear_s;
    logic [NCS-1:0] cell_resp_s;
    logic           resp_valid_s;
    logic           resp_ready_s = 1'b0;
    logic [0:0]     resp_data_s;
`ifdef PICO_PUF_UNSTABLE_FLAG_EN
    logic [0:0]     resp_unstable_s;
`endif

    pico_puf_array_ctrl dut (
        .clk           (clk),
        .clear         (clear),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_chal      (req_chal),
        .cell_clear    (cell_clear),
        .cell_resp     (cell_resp),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
`ifdef PICO_PUF_UNSTABLE_FLAG_EN
        .resp_unstable (resp_unstable),
`endif
        .resp_data     (resp_data)
    );

    pico_puf_array_ctrl #(
        .NUM_CELLS     (NCS),
        .RESP_W        (1),
        .NUM_EVAL      (1),
        .SETTLE_CYC    (1)
    ) dut_s (
        .clk           (clk),
        .clear         (clear),
        .req_valid     (req_valid_s),
        .req_ready     (req_ready_s),
        .req_chal      (req_chal_s),
        .cell_clear    (cell_clear_s),
        .cell_resp     (cell_resp_s),
        .resp_valid    (resp_valid_s),
        .resp_ready    (resp_ready_s),
`ifdef PICO_PUF_UNSTABLE_FLAG_EN
        .resp_unstable (resp_unstable_s),
`endif
        .resp_data     (resp_data_s)
    );

    // ------------------------------------------------------------------------
    // Cell stubs: a released cell returns tbl[k][n] where n is the number of
    // release windows cell k has already seen in this request; cells held in
    // clear return random garbage.
    // ------------------------------------------------------------------------
    bit         tbl   [NC][8];
    bit         tbl_s [NCS];
    logic [NC-1:0] garb = '0;
    logic [2:0] ecnt  [NC];
    logic [NC-1:0] prev_cc = '0;
    int         clr_cycles = 0;
    int         oh_bad = 0;
    int         checks = 0;
    int         errors = 0;

    for (genvar k = 0; k < NC; k++) begin : g_cell
        assign cell_resp[k] = cell_clear[k] ? tbl[k][ecnt[k]] : garb[k];
    end
    for (genvar k = 0; k < NCS; k++) begin : g_cell_s
        assign cell_resp_s[k] = cell_clear_s[k] ? tbl_s[k] : garb[k];
    end

    always @(negedge clk) begin
        garb = NC'($urandom);
        if (req_ready) begin
            for (int k = 0; k < NC; k++) ecnt[k] = 3'd0;
            clr_cycles = 0;
            oh_bad     = 0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (prev_cc[k] && !cell_clear[k]) ecnt[k] = ecnt[k] + 3'd1;
            end
            if (cell_clear != '0) clr_cycles++;
            if (!$onehot0(cell_clear)) oh_bad++;
        end
        prev_cc = cell_clear;
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Majority over the evaluation table for cells chal, chal+1, ... mod NC.
    function automatic void model(input int chal, output logic [RW-1:0] d,
                                  output logic [RW-1:0] u);
        d = '0;
        u = '0;
        for (int i = 0; i < RW; i++) begin
            int k;
            int ones;
            k    = (chal + i) % NC;
            ones = 0;
            for (int e = 0; e < NE; e++) ones += int'(tbl[k][e]);
            d[i] = (ones > NE / 2);
            u[i] = (ones != 0) && (ones != NE);
        end
    endfunction

    task automatic fill_tbl(input int mode);
        for (int k = 0; k < NC; k++) begin
            for (int e = 0; e < 8; e++) begin
                case (mode)
                    0:       tbl[k][e] = ((k % 3) == 0);
                    1:       tbl[k][e] = (k % 2 == 1);
                    default: tbl[k][e] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    endtask

    task automatic run_txn(input string tag, input int chal, input bit ack);
        logic [RW-1:0] exp_d;
        logic [RW-1:0] exp_u;
        int  n;
        bit  seen;
        model(chal, exp_d, exp_u);
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        req_chal  = 4'(chal);
        req_valid = 1'b1;
        n    = 0;
        seen = 0;
        // n counts rising edges from the accepting edge (edge 1) onward.
        while (!seen && n < LAT + 50) begin
            @(negedge clk);
            n++;
            req_valid = 1'b0;
            if (resp_valid) seen = 1;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_data"}, 64'(resp_data), 64'(exp_d));
`ifdef PICO_PUF_UNSTABLE_FLAG_EN
        check({tag, "_unstable"}, 64'(resp_unstable), 64'(exp_u));
`endif
        check({tag, "_release_cycles"}, 64'(clr_cycles), 64'(RW * NE * ST));
        check({tag, "_onehot"}, 64'(oh_bad), 64'd0);
        if (ack) begin
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            check({tag, "_ack_valid"}, 64'(resp_valid), 64'd0);
            check({tag, "_ack_ready"}, 64'(req_ready), 64'd1);
            check({tag, "_ack_data"}, 64'(resp_data), 64'(exp_d));
        end
    endtask

    task automatic run_small(input string tag);
        int n;
        bit seen;
        int chal;
        chal = $urandom_range(0, NCS - 1);
        for (int k = 0; k < NCS; k++) tbl_s[k] = 1'($urandom_range(0, 1));
        n = 0;
        while (!req_ready_s && n < 100) begin @(negedge clk); n++; end
        check({tag, "_ready"}, 64'(req_ready_s), 64'd1);
        req_chal_s  = 2'(chal);
        req_valid_s = 1'b1;
        n    = 0;
        seen = 0;
        while (!seen && n < LAT_S + 20) begin
            @(negedge clk);
            n++;
            req_valid_s = 1'b0;
            if (resp_valid_s) seen = 1;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT_S));
        check({tag, "_data"}, 64'(resp_data_s), 64'(tbl_s[chal]));
        resp_ready_s = 1'b1;
        @(negedge clk);
        resp_ready_s = 1'b0;
        check({tag, "_ack_valid"}, 64'(resp_valid_s), 64'd0);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [RW-1:0] held;
        int bad;
        for (int k = 0; k < NC; k++) ecnt[k] = 3'd0;
        fill_tbl(0);

        // reset state
        #12;
        check("rst_cell_clear", 64'(cell_clear), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // constant cells k%3==0 from cell 0: expect 8'b0100_1001
        fill_tbl(0);
        run_txn("const", 0, 1'b1);
        check("const_literal", 64'(resp_data), 64'h49);

        // wrap-around: 14,15,0..5 with cell k returning k[0]
        fill_tbl(1);
        run_txn("wrap", 14, 1'b1);
        check("wrap_literal", 64'(resp_data), 64'hAA);

        // 4-of-7 majority on cell 3
        fill_tbl(1);
        tbl[3][0] = 1; tbl[3][1] = 1; tbl[3][2] = 0; tbl[3][3] = 1;
        tbl[3][4] = 0; tbl[3][5] = 0; tbl[3][6] = 1;
        run_txn("maj", 3, 1'b0);
        check("maj_bit0", 64'(resp_data[0]), 64'd1);

        // hold the response with resp_ready low; requests must be ignored
        held = resp_data;
        bad  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            req_valid = 1'(i % 2);
            if (!resp_valid || resp_data !== held || req_ready) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        // handshake and a request in the same cycle: request not taken
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        check("hold_ack_valid", 64'(resp_valid), 64'd0);
        check("hold_same_cycle_req", 64'(req_ready), 64'd1);
        check("hold_ack_data", 64'(resp_data), 64'(held));

        // randomized tables and challenges
        for (int r = 0; r < 3; r++) begin
            fill_tbl(2);
            run_txn("rand", $urandom_range(0, NC - 1), 1'b1);
        end

        // asynchronous reset in the middle of EVAL (edge 100 of the request)
        fill_tbl(0);
        req_chal  = 4'd0;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check("abort_pre_release", 64'(cell_clear != '0), 64'd1);
        clear = 1'b0;
        #1;
        check("abort_cell_clear", 64'(cell_clear), 64'd0);
        check("abort_resp_valid", 64'(resp_valid), 64'd0);
        check("abort_resp_data", 64'(resp_data), 64'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        run_txn("post_abort", 0, 1'b1);

        // minimal configuration
        run_small("small_a");
        run_small("small_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pico_puf_array_ctrl
`default_nettype wire
